// File: rtl/isa_pkg.sv
// Shared ISA definitions for the decode stage: opcodes, control-bit layout
// and the packed ID/EX pipeline register bundle.
package isa_pkg;

  localparam logic [5:0] OP_ADD  = 6'b000000;
  localparam logic [5:0] OP_SUB  = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b000001;
  localparam logic [5:0] OP_LDW  = 6'b001100;
  localparam logic [5:0] OP_STW  = 6'b001101;
  localparam logic [5:0] OP_BEQ  = 6'b001111;
  localparam logic [5:0] OP_JR   = 6'b010000;
  localparam logic [5:0] OP_HALT = 6'b010001;

  localparam int CTRL_REG_WE  = 7;
  localparam int CTRL_MEM_RD  = 6;
  localparam int CTRL_MEM_WE  = 5;
  localparam int CTRL_ALU_SRC = 4;
  localparam int CTRL_IS_BR   = 3;
  localparam int CTRL_IS_JR   = 2;
  localparam int CTRL_HALT    = 1;
  localparam int CTRL_ALU_SUB = 0;

  // Field order matches the bit indices above (first field is the MSB).
  typedef struct packed {
    logic reg_we;
    logic mem_rd;
    logic mem_we;
    logic alu_src;
    logic is_br;
    logic is_jr;
    logic halt;
    logic alu_sub;
  } ctrl_t;

  typedef struct packed {
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic [31:0] imm;
    logic [4:0]  dest;
    ctrl_t       ctrl;
    logic [31:0] add;
    logic [31:0] pc4;
  } idex_t;

endpackage

// File: rtl/inst_d_if.sv
// Fetch-to-decode link: instruction word and PC+4 forward, stall request back.
interface inst_d_if;

  logic [31:0] instruction;
  logic [31:0] pc4_dc;
  logic        hazard;

  modport master (output instruction, output pc4_dc, input hazard);
  modport slave  (input instruction, input pc4_dc, output hazard);

endinterface

// File: rtl/reg_file.sv
// Architectural register file with write-through read ports; r0 is hardwired
// to zero and the array is intentionally left out of reset.
module reg_file #(
  parameter int NREG = 32,
  parameter int DW   = 32
) (
  input  logic          clk,
  input  logic          we,
  input  logic [4:0]    waddr,
  input  logic [DW-1:0] wdata,
  input  logic [4:0]    raddr_a,
  input  logic [4:0]    raddr_b,
  output logic [DW-1:0] rdata_a,
  output logic [DW-1:0] rdata_b
);

  logic [DW-1:0] mem [NREG];

  always_ff @(posedge clk) begin
    if (we && waddr != 5'd0) begin
      mem[waddr] <= wdata;
    end
  end

  // Same-cycle writeback is forwarded so decode never sees a stale value.
  always_comb begin
    rdata_a = '0;
    if (raddr_a != 5'd0) begin
      rdata_a = (we && waddr == raddr_a) ? wdata : mem[raddr_a];
    end
  end

  always_comb begin
    rdata_b = '0;
    if (raddr_b != 5'd0) begin
      rdata_b = (we && waddr == raddr_b) ? wdata : mem[raddr_b];
    end
  end

endmodule

// File: rtl/inst_d.sv
// Instruction decode stage: IF/ID register, register-file read, load-use
// stall detection and the ID/EX pipeline register.
module inst_d
  import isa_pkg::*;
#(
  parameter int NREG = 32,
  parameter int DW   = 32
) (
  input  logic          clk,
  input  logic          rst,
  inst_d_if.slave       fe,
  input  logic          flush,
  input  logic          wb_we,
  input  logic [4:0]    wb_rd,
  input  logic [DW-1:0] wb_data,
  output logic [DW-1:0] ex_rs_val,
  output logic [DW-1:0] ex_rt_val,
  output logic [DW-1:0] ex_imm,
  output logic [4:0]    ex_dest,
  output logic [7:0]    ex_ctrl,
  output logic [DW-1:0] ex_add,
  output logic [DW-1:0] ex_pc4
);

  logic [31:0]   instr_q, instr_d;
  logic [DW-1:0] pc4_q, pc4_d;
  idex_t         idex_q, idex_d;

  logic [5:0]    op;
  logic [4:0]    rs, rt, rd;
  logic [15:0]   imm;
  logic [7:0]    ctrl_bits;
  logic [4:0]    dest;
  logic          uses_rs, uses_rt;
  logic [DW-1:0] imm_ext;
  logic [DW-1:0] rs_val, rt_val;
  logic          load_use;

  assign op  = instr_q[31:26];
  assign rs  = instr_q[25:21];
  assign rt  = instr_q[20:16];
  assign rd  = instr_q[15:11];
  assign imm = instr_q[15:0];

  reg_file #(.NREG(NREG), .DW(DW)) u_reg_file (
    .clk     (clk),
    .we      (wb_we),
    .waddr   (wb_rd),
    .wdata   (wb_data),
    .raddr_a (rs),
    .raddr_b (rt),
    .rdata_a (rs_val),
    .rdata_b (rt_val)
  );

  always_comb begin
    ctrl_bits = '0;
    dest      = '0;
    uses_rs   = 1'b0;
    uses_rt   = 1'b0;
    case (op)
      OP_ADD:  begin ctrl_bits[CTRL_REG_WE] = 1'b1; dest = rd; uses_rs = 1'b1; uses_rt = 1'b1; end
      OP_SUB:  begin ctrl_bits[CTRL_REG_WE] = 1'b1; ctrl_bits[CTRL_ALU_SUB] = 1'b1;
                     dest = rd; uses_rs = 1'b1; uses_rt = 1'b1; end
      OP_ADDI: begin ctrl_bits[CTRL_REG_WE] = 1'b1; ctrl_bits[CTRL_ALU_SRC] = 1'b1;
                     dest = rt; uses_rs = 1'b1; end
      OP_LDW:  begin ctrl_bits[CTRL_REG_WE] = 1'b1; ctrl_bits[CTRL_MEM_RD] = 1'b1;
                     ctrl_bits[CTRL_ALU_SRC] = 1'b1; dest = rt; uses_rs = 1'b1; end
      OP_STW:  begin ctrl_bits[CTRL_MEM_WE] = 1'b1; ctrl_bits[CTRL_ALU_SRC] = 1'b1;
                     uses_rs = 1'b1; uses_rt = 1'b1; end
      OP_BEQ:  begin ctrl_bits[CTRL_IS_BR] = 1'b1; uses_rs = 1'b1; uses_rt = 1'b1; end
      OP_JR:   begin ctrl_bits[CTRL_IS_JR] = 1'b1; uses_rs = 1'b1; end
      OP_HALT: begin ctrl_bits[CTRL_HALT] = 1'b1; end
      default: ;
    endcase
    // Writing r0 is meaningless, so the write enable is dropped; this also
    // keeps the all-zero word a true no-op.
    if (dest == 5'd0) begin
      ctrl_bits[CTRL_REG_WE] = 1'b0;
    end
  end

  assign imm_ext = {{16{imm[15]}}, imm};

  assign load_use = idex_q.ctrl.mem_rd && (idex_q.dest != 5'd0) &&
                    ((uses_rs && idex_q.dest == rs) || (uses_rt && idex_q.dest == rt)) &&
                    !flush;
  assign fe.hazard = load_use;

  always_comb begin
    instr_d = instr_q;
    pc4_d   = pc4_q;
    if (flush) begin
      instr_d = '0;
      pc4_d   = '0;
    end else if (!load_use) begin
      instr_d = fe.instruction;
      pc4_d   = fe.pc4_dc;
    end
  end

  // A stall or flush injects an all-zero bubble into EX.
  always_comb begin
    idex_d = '0;
    if (!flush && !load_use) begin
      idex_d.rs_val = rs_val;
      idex_d.rt_val = rt_val;
      idex_d.imm    = imm_ext;
      idex_d.dest   = dest;
      idex_d.ctrl   = ctrl_t'(ctrl_bits);
      idex_d.add    = pc4_q + (imm_ext << 2);
      idex_d.pc4    = pc4_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      instr_q <= '0;
      pc4_q   <= '0;
      idex_q  <= '0;
    end else begin
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      idex_q  <= idex_d;
    end
  end

  assign ex_rs_val = idex_q.rs_val;
  assign ex_rt_val = idex_q.rt_val;
  assign ex_imm    = idex_q.imm;
  assign ex_dest   = idex_q.dest;
  assign ex_ctrl   = idex_q.ctrl;
  assign ex_add    = idex_q.add;
  assign ex_pc4    = idex_q.pc4;

endmodule
